// File: rtl/cpu_pkg.sv
// ---------------------------------------------------------------------------
// cpu_pkg
//   Shared constants and types for the CPU datapath. The register file and
//   its read-port helper import this package so that widths and the
//   hardwired zero register are defined in exactly one place.
//
//   Contents
//     DATA_W     register / datapath width in bits
//     ADDR_W     register address width in bits
//     NUM_REGS   register count, always 2**ADDR_W
//     ZERO_REG   index of the hardwired-zero register
//     word_t     one datapath word
//     reg_addr_t one register address
//     isZeroReg  true when an address names the hardwired-zero register
// ---------------------------------------------------------------------------
package cpu_pkg;

  localparam int DATA_W   = 32;
  localparam int ADDR_W   = 5;
  localparam int NUM_REGS = 1 << ADDR_W;
  localparam int ZERO_REG = 0;

  typedef logic [DATA_W-1:0] word_t;
  typedef logic [ADDR_W-1:0] reg_addr_t;

  // Convenience test for the hardwired-zero register at the package widths.
  function automatic logic isZeroReg(input reg_addr_t addr);
    return addr == reg_addr_t'(ZERO_REG);
  endfunction

endpackage : cpu_pkg

// File: rtl/reg_file_rd_port.sv
// ---------------------------------------------------------------------------
// reg_file_rd_port
//   One combinational read port of the register file. Selects a stored
//   register by address, forces the hardwired-zero register to read 0, and,
//   when the build defines REG_FILE_BYPASS_EN, forwards the write port's data
//   when it targets the same nonzero register in the same cycle.
//
//   Configuration macro: REG_FILE_BYPASS_EN (write-through bypass)
//
//   Ports
//     regs_i   in   (NUM_REGS-1)*DATA_W  flattened storage, entries 1..NUM_REGS-1
//     raddr_i  in   ADDR_W               read address
//     we_i     in   1                    write enable    (bypass build only)
//     waddr_i  in   ADDR_W               write address   (bypass build only)
//     wdata_i  in   DATA_W               write data      (bypass build only)
//     rdata_o  out  DATA_W               read data, zero cycles of latency
// ---------------------------------------------------------------------------
module reg_file_rd_port
  import cpu_pkg::*;
#(
  parameter  int DATA_W   = cpu_pkg::DATA_W,
  parameter  int ADDR_W   = cpu_pkg::ADDR_W,
  localparam int NUM_REGS = 1 << ADDR_W
) (
  input  logic [NUM_REGS-1:1][DATA_W-1:0] regs_i,
  input  logic [ADDR_W-1:0]               raddr_i,
`ifdef REG_FILE_BYPASS_EN
  input  logic                            we_i,
  input  logic [ADDR_W-1:0]               waddr_i,
  input  logic [DATA_W-1:0]               wdata_i,
`endif
  output logic [DATA_W-1:0]               rdata_o
);

  localparam logic [ADDR_W-1:0] ZeroAddr = ADDR_W'(ZERO_REG);

  logic [DATA_W-1:0] storedData;
  logic              readsZero;

  // Address decode into the stored entries. Entry 0 has no storage, so the
  // loop starts at 1 and an address of 0 falls through to the zero default.
  always_comb begin
    storedData = '0;
    for (int i = 1; i < NUM_REGS; i++) begin
      if (raddr_i == ADDR_W'(i)) begin
        storedData = regs_i[i];
      end
    end
  end

  assign readsZero = (raddr_i == ZeroAddr);

`ifdef REG_FILE_BYPASS_EN
  logic bypassHit;

  // A same-cycle write to the register being read is forwarded so the
  // consumer sees the new value without waiting for the write edge. Writes
  // to the zero register never qualify because they are discarded anyway.
  assign bypassHit = we_i && (waddr_i != ZeroAddr) && (waddr_i == raddr_i);

  // Zero forcing has priority over the bypass so register 0 always reads 0.
  always_comb begin
    rdata_o = storedData;
    if (readsZero) begin
      rdata_o = '0;
    end else if (bypassHit) begin
      rdata_o = wdata_i;
    end
  end
`else
  // Without bypass the port returns the stored (old) value in a write cycle.
  always_comb begin
    rdata_o = storedData;
    if (readsZero) begin
      rdata_o = '0;
    end
  end
`endif

endmodule : reg_file_rd_port

// File: rtl/reg_file.sv
// ---------------------------------------------------------------------------
// reg_file
//   General-purpose register file with two combinational read ports and one
//   synchronous write port. Register 0 is hardwired to zero and has no
//   storage. Read data feeds the ALU operand muxes (rdata1 -> a, rdata2 -> b).
//
//   Configuration macro: REG_FILE_BYPASS_EN
//     defined   : a same-cycle write to the address being read is forwarded
//                 to that read port (each port independently)
//     undefined : read ports show the old value during the write cycle
//
//   Ports
//     clk     in   1       rising-edge clock
//     rst_n   in   1       synchronous reset, active low; clears every register
//                          and discards any write in the same cycle
//     we      in   1       write enable
//     waddr   in   ADDR_W  write address (0 is ignored)
//     wdata   in   DATA_W  write data
//     raddr1  in   ADDR_W  read port 1 address
//     rdata1  out  DATA_W  read port 1 data
//     raddr2  in   ADDR_W  read port 2 address
//     rdata2  out  DATA_W  read port 2 data
// ---------------------------------------------------------------------------
module reg_file
  import cpu_pkg::*;
#(
  parameter  int DATA_W   = cpu_pkg::DATA_W,
  parameter  int ADDR_W   = cpu_pkg::ADDR_W,
  localparam int NUM_REGS = 1 << ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr1,
  output logic [DATA_W-1:0] rdata1,
  input  logic [ADDR_W-1:0] raddr2,
  output logic [DATA_W-1:0] rdata2
);

  localparam logic [ADDR_W-1:0] ZeroAddr = ADDR_W'(ZERO_REG);

  // Storage for registers 1..NUM_REGS-1 only; register 0 is never built.
  logic [NUM_REGS-1:1][DATA_W-1:0] regs_q;
  logic [NUM_REGS-1:1][DATA_W-1:0] regs_d;

  logic writeValid;

  assign writeValid = we && (waddr != ZeroAddr);

  // Next-state: hold every register, replace only the addressed one. A write
  // to address 0 matches no entry, which is how it is silently dropped.
  always_comb begin
    regs_d = regs_q;
    if (writeValid) begin
      for (int i = 1; i < NUM_REGS; i++) begin
        if (waddr == ADDR_W'(i)) begin
          regs_d[i] = wdata;
        end
      end
    end
  end

  // Reset wins over any write presented in the same cycle, so a write that
  // coincides with rst_n=0 is lost and the next one after release lands.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      regs_q <= '0;
    end else begin
      regs_q <= regs_d;
    end
  end

  // Two identical, independent read ports.
  reg_file_rd_port #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_rd_port1 (
    .regs_i  (regs_q),
    .raddr_i (raddr1),
`ifdef REG_FILE_BYPASS_EN
    .we_i    (we),
    .waddr_i (waddr),
    .wdata_i (wdata),
`endif
    .rdata_o (rdata1)
  );

  reg_file_rd_port #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_rd_port2 (
    .regs_i  (regs_q),
    .raddr_i (raddr2),
`ifdef REG_FILE_BYPASS_EN
    .we_i    (we),
    .waddr_i (waddr),
    .wdata_i (wdata),
`endif
    .rdata_o (rdata2)
  );

endmodule : reg_file

// File: tb/tb_reg_file.sv
// ---------------------------------------------------------------------------
// tb_reg_file
//   Directed, self-checking bench for reg_file. Inputs change on the falling
//   edge; reads are sampled 1 time unit later, well away from the rising edge
//   that commits writes.
// ---------------------------------------------------------------------------
module tb_reg_file;

  logic        clk;
  logic        rst_n;
  logic        we;
  logic [4:0]  waddr;
  logic [31:0] wdata;
  logic [4:0]  raddr1;
  logic [31:0] rdata1;
  logic [4:0]  raddr2;
  logic [31:0] rdata2;

  int total;
  int bad;

  reg_file dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .we     (we),
    .waddr  (waddr),
    .wdata  (wdata),
    .raddr1 (raddr1),
    .rdata1 (rdata1),
    .raddr2 (raddr2),
    .rdata2 (rdata2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Present a write on the falling edge; it commits on the next rising edge
  // and we is dropped again at the following falling edge.
  task automatic doWrite(input logic [4:0] addr, input logic [31:0] data);
    @(negedge clk);
    we    = 1'b1;
    waddr = addr;
    wdata = data;
    @(negedge clk);
    we    = 1'b0;
  endtask

  task automatic test_reset();
    $display("[TB] test_reset");
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 32; i++) begin
      raddr1 = 5'(i);
      raddr2 = 5'(31 - i);
      #1;
      total++;
      if (rdata1 !== 32'h0) begin
        bad++;
        $display("[TB] FAIL reset_p1 r%0d got=%h exp=%h", i, rdata1, 32'h0);
      end
      total++;
      if (rdata2 !== 32'h0) begin
        bad++;
        $display("[TB] FAIL reset_p2 r%0d got=%h exp=%h", 31 - i, rdata2, 32'h0);
      end
    end
    // Write r5, confirm it stuck, then clear it with a one-edge reset.
    doWrite(5'd5, 32'hDEADBEEF);
    raddr1 = 5'd5;
    #1;
    total++;
    if (rdata1 !== 32'hDEADBEEF) begin
      bad++;
      $display("[TB] FAIL pre_reset_r5 got=%h exp=%h", rdata1, 32'hDEADBEEF);
    end
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 1; i < 32; i++) begin
      raddr1 = 5'(i);
      #1;
      total++;
      if (rdata1 !== 32'h0) begin
        bad++;
        $display("[TB] FAIL post_reset r%0d got=%h exp=%h", i, rdata1, 32'h0);
      end
    end
  endtask

  task automatic test_write_read();
    $display("[TB] test_write_read");
    doWrite(5'd3, 32'h12345678);
    raddr1 = 5'd3;
    raddr2 = 5'd3;
    #1;
    total++;
    if (rdata1 !== 32'h12345678) begin
      bad++;
      $display("[TB] FAIL wr_rd_p1 got=%h exp=%h", rdata1, 32'h12345678);
    end
    total++;
    if (rdata2 !== 32'h12345678) begin
      bad++;
      $display("[TB] FAIL wr_rd_p2 got=%h exp=%h", rdata2, 32'h12345678);
    end
    // A different register stays untouched.
    raddr2 = 5'd4;
    #1;
    total++;
    if (rdata2 !== 32'h0) begin
      bad++;
      $display("[TB] FAIL wr_rd_other got=%h exp=%h", rdata2, 32'h0);
    end
  endtask

  task automatic test_zero_reg();
    $display("[TB] test_zero_reg");
    @(negedge clk);
    we     = 1'b1;
    waddr  = 5'd0;
    wdata  = 32'hFFFFFFFF;
    raddr1 = 5'd0;
    raddr2 = 5'd0;
    #1;
    total++;
    if (rdata1 !== 32'h0) begin
      bad++;
      $display("[TB] FAIL zero_same_cycle_p1 got=%h exp=%h", rdata1, 32'h0);
    end
    total++;
    if (rdata2 !== 32'h0) begin
      bad++;
      $display("[TB] FAIL zero_same_cycle_p2 got=%h exp=%h", rdata2, 32'h0);
    end
    @(negedge clk);
    we = 1'b0;
    #1;
    total++;
    if (rdata1 !== 32'h0) begin
      bad++;
      $display("[TB] FAIL zero_after_edge got=%h exp=%h", rdata1, 32'h0);
    end
  endtask

  task automatic test_hazard();
    logic [31:0] expSame;
`ifdef REG_FILE_BYPASS_EN
    expSame = 32'h22;
`else
    expSame = 32'h11;
`endif
    $display("[TB] test_hazard");
    doWrite(5'd7, 32'h11);
    @(negedge clk);
    we     = 1'b1;
    waddr  = 5'd7;
    wdata  = 32'h22;
    raddr1 = 5'd7;
    raddr2 = 5'd3;
    #1;
    total++;
    if (rdata1 !== expSame) begin
      bad++;
      $display("[TB] FAIL hazard_same_cycle got=%h exp=%h", rdata1, expSame);
    end
    // The other port reads an unrelated register and is never bypassed.
    total++;
    if (rdata2 !== 32'h12345678) begin
      bad++;
      $display("[TB] FAIL hazard_other_port got=%h exp=%h", rdata2, 32'h12345678);
    end
    @(negedge clk);
    we = 1'b0;
    #1;
    total++;
    if (rdata1 !== 32'h22) begin
      bad++;
      $display("[TB] FAIL hazard_after_edge got=%h exp=%h", rdata1, 32'h22);
    end
  endtask

  task automatic test_reset_with_write();
    $display("[TB] test_reset_with_write");
    @(negedge clk);
    rst_n = 1'b0;
    we    = 1'b1;
    waddr = 5'd9;
    wdata = 32'hA5;
    @(negedge clk);
    rst_n  = 1'b1;
    we     = 1'b0;
    raddr1 = 5'd9;
    raddr2 = 5'd7;
    #1;
    total++;
    if (rdata1 !== 32'h0) begin
      bad++;
      $display("[TB] FAIL rst_write_lost got=%h exp=%h", rdata1, 32'h0);
    end
    total++;
    if (rdata2 !== 32'h0) begin
      bad++;
      $display("[TB] FAIL rst_clears_r7 got=%h exp=%h", rdata2, 32'h0);
    end
    // Back-to-back: reset again, then write in the very first released cycle.
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    we    = 1'b1;
    waddr = 5'd9;
    wdata = 32'h5A;
    @(negedge clk);
    we = 1'b0;
    #1;
    total++;
    if (rdata1 !== 32'h5A) begin
      bad++;
      $display("[TB] FAIL first_write_after_rst got=%h exp=%h", rdata1, 32'h5A);
    end
  endtask

  task automatic test_sweep();
    logic [31:0] exp1;
    logic [31:0] exp2;
    $display("[TB] test_sweep");
    for (int i = 1; i < 32; i++) begin
      doWrite(5'(i), 32'(i) * 32'h01010101);
    end
    for (int i = 0; i < 32; i++) begin
      raddr1 = 5'(i);
      raddr2 = 5'(31 - i);
      exp1   = 32'(i) * 32'h01010101;
      exp2   = 32'(31 - i) * 32'h01010101;
      #1;
      total++;
      if (rdata1 !== exp1) begin
        bad++;
        $display("[TB] FAIL sweep_p1 r%0d got=%h exp=%h", i, rdata1, exp1);
      end
      total++;
      if (rdata2 !== exp2) begin
        bad++;
        $display("[TB] FAIL sweep_p2 r%0d got=%h exp=%h", 31 - i, rdata2, exp2);
      end
    end
  endtask

  initial begin
    total  = 0;
    bad    = 0;
    rst_n  = 1'b0;
    we     = 1'b0;
    waddr  = 5'd0;
    wdata  = 32'h0;
    raddr1 = 5'd0;
    raddr2 = 5'd0;

    test_reset();
    test_write_read();
    test_zero_reg();
    test_hazard();
    test_reset_with_write();
    test_sweep();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_reg_file
